// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: merges the writeback stream and FIFO-buffered MDU results onto one register-file write port.
// Define WB_PENDING_EN to drive pending_mask from live queued entries; otherwise it is tied to 0.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_wr,
    input  logic [4:0]            pipe_rd,
    input  logic [DATA_WIDTH-1:0] pipe_data,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [4:0]            mdu_rd,
    input  logic [DATA_WIDTH-1:0] mdu_data,
    output logic                  reg_write,
    output logic [4:0]            reg_we,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic [31:0]           pending_mask
);
    localparam int PW = $clog2(FIFO_DEPTH);
    logic [4:0]            rd_q   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] live_q;
    logic [PW-1:0]         wptr, rptr;
    logic [PW:0]           count;
    logic                  pipe_go, head_live, drain, pop, push, push_live;
    assign mdu_ready = count != (PW+1)'(FIFO_DEPTH);
    assign pipe_go   = pipe_wr && pipe_rd != 5'd0;
    // live bits are cleared on pop, so a live bit also implies the slot is occupied
    assign head_live = live_q[rptr];
    assign drain     = !pipe_go && head_live && rd_q[rptr] != 5'd0;
    assign pop       = count != '0 && (drain || !head_live);
    assign push      = mdu_valid && mdu_ready && mdu_rd != 5'd0;
    assign push_live = !(pipe_go && pipe_rd == mdu_rd);
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wptr]   <= mdu_rd;
            data_q[wptr] <= mdu_data;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q    <= '0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            reg_write <= 1'b0;
            reg_we    <= '0;
            reg_wdata <= '0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                if (pipe_go && rd_q[i] == pipe_rd) live_q[i] <= 1'b0;
            if (pop) begin
                live_q[rptr] <= 1'b0;
                rptr         <= rptr + 1'b1;
            end
            if (push) begin
                live_q[wptr] <= push_live;
                wptr         <= wptr + 1'b1;
            end
            count     <= count + (PW+1)'(push) - (PW+1)'(pop);
            reg_write <= pipe_go || drain;
            reg_we    <= pipe_go ? pipe_rd : drain ? rd_q[rptr] : '0;
            reg_wdata <= pipe_go ? pipe_data : drain ? data_q[rptr] : '0;
        end
    end
`ifdef WB_PENDING_EN
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++)
            if (live_q[i]) pending_mask = pending_mask | (32'd1 << rd_q[i]);
    end
`else
    assign pending_mask = '0;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: vector table, scoreboarded random traffic and mid-operation reset for regfile_write_arbiter.
module tb_regfile_write_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_wr = 1'b0, mdu_valid = 1'b0;
    logic [4:0]  pipe_rd = '0, mdu_rd = '0;
    logic [31:0] pipe_data = '0, mdu_data = '0;
    logic        mdu_ready, reg_write;
    logic [4:0]  reg_we;
    logic [31:0] reg_wdata, pending_mask;
    int tests = 0, fails = 0;
    logic sb_on = 1'b0;

    typedef struct {
        logic pw; logic [4:0] prd; logic [31:0] pd;
        logic mv; logic [4:0] mrd; logic [31:0] md;
        logic ew; logic [4:0] ewe; logic [31:0] ewd;
        logic er; logic [31:0] epm;
    } vec_t;
    typedef struct { logic [4:0] rd; logic [31:0] d; } wr_t;
    localparam int NV = 27;
    vec_t tv [NV];
    wr_t pipe_q [$];
    wr_t mdu_q [$];

    regfile_write_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_wr(pipe_wr), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .reg_write(reg_write), .reg_we(reg_we), .reg_wdata(reg_wdata),
        .pending_mask(pending_mask)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pm(input logic [31:0] m);
`ifdef WB_PENDING_EN
        return m;
`else
        return 32'd0;
`endif
    endfunction

    function automatic vec_t mk(input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                                input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                                input logic ew, input logic [4:0] ewe, input logic [31:0] ewd,
                                input logic er, input logic [31:0] epm);
        vec_t v;
        v.pw = pw; v.prd = prd; v.pd = pd; v.mv = mv; v.mrd = mrd; v.md = md;
        v.ew = ew; v.ewe = ewe; v.ewd = ewd; v.er = er; v.epm = epm;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        pipe_wr = pw; pipe_rd = prd; pipe_data = pd;
        mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
    endtask

    // scoreboard monitor: r31 writes come from the pipeline, all others from the MDU
    always @(posedge clk) begin
        if (sb_on) begin
            #1;
            if (reg_write) begin
                wr_t e;
                chk("sb_we_nonzero", 64'(reg_we != 5'd0), 64'd1);
                if (reg_we == 5'd31 ? pipe_q.size() == 0 : mdu_q.size() == 0) begin
                    chk("sb_unexpected_write", 64'(reg_we), 64'd0);
                end else begin
                    e = reg_we == 5'd31 ? pipe_q.pop_front() : mdu_q.pop_front();
                    chk("sb_rd", 64'(reg_we), 64'(e.rd));
                    chk("sb_data", 64'(reg_wdata), 64'(e.d));
                end
            end
            chk("sb_pipe_latency", 64'(pipe_q.size()), 64'd0);
        end
    end

    initial begin
        tv[0]  = mk(1, 5, 32'h1234, 0, 0, 0,        1, 5, 32'h1234, 1, 32'h0);
        tv[1]  = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,        1, 32'h0);
        tv[2]  = mk(0, 0, 0,        1, 8, 32'hAA,   0, 0, 0,        1, 32'h100);
        tv[3]  = mk(0, 0, 0,        0, 0, 0,        1, 8, 32'hAA,   1, 32'h0);
        tv[4]  = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,        1, 32'h0);
        tv[5]  = mk(1, 3, 32'h31,   1, 10, 32'hA0,  1, 3, 32'h31,   1, 32'h0400);
        tv[6]  = mk(1, 3, 32'h32,   1, 11, 32'hA1,  1, 3, 32'h32,   1, 32'h0C00);
        tv[7]  = mk(1, 3, 32'h33,   1, 12, 32'hA2,  1, 3, 32'h33,   1, 32'h1C00);
        tv[8]  = mk(1, 3, 32'h34,   1, 13, 32'hA3,  1, 3, 32'h34,   0, 32'h3C00);
        tv[9]  = mk(1, 3, 32'h35,   1, 14, 32'hB0,  1, 3, 32'h35,   0, 32'h3C00);
        tv[10] = mk(0, 0, 0,        1, 14, 32'hB0,  1, 10, 32'hA0,  1, 32'h3800);
        tv[11] = mk(0, 0, 0,        1, 14, 32'hB0,  1, 11, 32'hA1,  1, 32'h7000);
        tv[12] = mk(0, 0, 0,        0, 0, 0,        1, 12, 32'hA2,  1, 32'h6000);
        tv[13] = mk(0, 0, 0,        0, 0, 0,        1, 13, 32'hA3,  1, 32'h4000);
        tv[14] = mk(0, 0, 0,        0, 0, 0,        1, 14, 32'hB0,  1, 32'h0);
        tv[15] = mk(1, 3, 32'h40,   1, 9, 32'hC9,   1, 3, 32'h40,   1, 32'h200);
        tv[16] = mk(1, 9, 32'h77,   0, 0, 0,        1, 9, 32'h77,   1, 32'h0);
        tv[17] = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,        1, 32'h0);
        tv[18] = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,        1, 32'h0);
        tv[19] = mk(1, 6, 32'h66,   1, 6, 32'hD6,   1, 6, 32'h66,   1, 32'h0);
        tv[20] = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,        1, 32'h0);
        tv[21] = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,        1, 32'h0);
        tv[22] = mk(1, 3, 32'h50,   1, 4, 32'h44,   1, 3, 32'h50,   1, 32'h10);
        tv[23] = mk(1, 0, 32'h99,   0, 0, 0,        1, 4, 32'h44,   1, 32'h0);
        tv[24] = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,        1, 32'h0);
        tv[25] = mk(0, 0, 0,        1, 0, 32'h55,   0, 0, 0,        1, 32'h0);
        tv[26] = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,        1, 32'h0);

        #12;
        chk("rst_write", 64'(reg_write), 64'd0);
        chk("rst_we", 64'(reg_we), 64'd0);
        chk("rst_wdata", 64'(reg_wdata), 64'd0);
        chk("rst_ready", 64'(mdu_ready), 64'd1);
        chk("rst_pending", 64'(pending_mask), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            drive(tv[k].pw, tv[k].prd, tv[k].pd, tv[k].mv, tv[k].mrd, tv[k].md);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_write", k), 64'(reg_write), 64'(tv[k].ew));
            chk($sformatf("v%0d_we", k), 64'(reg_we), 64'(tv[k].ewe));
            chk($sformatf("v%0d_wdata", k), 64'(reg_wdata), 64'(tv[k].ewd));
            chk($sformatf("v%0d_ready", k), 64'(mdu_ready), 64'(tv[k].er));
            chk($sformatf("v%0d_pending", k), 64'(pending_mask), 64'(pm(tv[k].epm)));
        end

        // random mixed traffic: pipeline writes only r31, MDU writes r1..r30
        sb_on = 1'b1;
        for (int k = 0; k < 200; k++) begin
            logic pw, mv;
            wr_t e;
            @(negedge clk);
            pw = 1'($urandom_range(0, 1));
            mv = 1'($urandom_range(0, 1));
            drive(pw, pw ? 5'd31 : 5'($urandom_range(0, 31)), $urandom(),
                  mv, 5'($urandom_range(1, 30)), $urandom());
            if (pw) begin
                e.rd = 5'd31; e.d = pipe_data; pipe_q.push_back(e);
            end
            if (mv && mdu_ready) begin
                e.rd = mdu_rd; e.d = mdu_data; mdu_q.push_back(e);
            end
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 40 && mdu_q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        chk("sb_drain_empty", 64'(mdu_q.size()), 64'd0);
        sb_on = 1'b0;

        // reset with three entries queued behind a held pipeline write
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1, 3, 32'h60 + k, 1, 5'(20 + k), 32'hE0 + k);
        end
        @(negedge clk);
        drive(1, 3, 32'h63, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("prerst_write", 64'(reg_write), 64'd1);
        chk("prerst_pending", 64'(pending_mask), 64'(pm(32'h0070_0000)));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_write", 64'(reg_write), 64'd0);
        chk("midrst_we", 64'(reg_we), 64'd0);
        chk("midrst_wdata", 64'(reg_wdata), 64'd0);
        chk("midrst_ready", 64'(mdu_ready), 64'd1);
        chk("midrst_pending", 64'(pending_mask), 64'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("postrst%0d_write", k), 64'(reg_write), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
